// File: rtl/hazard_control_unit_if.sv
// ----------------------------------------------------------------------------
// hazard_control_unit_if
//
// Bundles the signals between the 5-stage pipeline and the hazard control
// unit.
//
// Pipeline -> hazard unit (driven by the master side):
//   ifIdRs, ifIdRt   source register specifiers of the instruction in ID
//   ifIdUsesRt       ID instruction reads rt as a source
//   idExRt           destination register of the instruction in EX
//   idExMemRead      EX instruction is a load
//   branchTaken      EX resolved a taken branch/jump this cycle
//   memReq           MEM stage is issuing a data memory access
//   memReady         data memory completes the access this cycle
//
// Hazard unit -> pipeline (driven by the slave side):
//   pcWrite, ifIdWrite       load enables for PC and IF/ID
//   ifIdFlush, idExBubble    squash IF/ID, insert bubble into ID/EX
//   pipeHold                 freeze ID/EX, EX/MEM, MEM/WB
//   stallCycles              saturating count of cycles with pcWrite low
//   memTimeout               sticky flag: a memory access was abandoned
// ----------------------------------------------------------------------------
interface hazard_control_unit_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic [REG_ADDR_WIDTH-1:0] ifIdRs;
    logic [REG_ADDR_WIDTH-1:0] ifIdRt;
    logic                      ifIdUsesRt;
    logic [REG_ADDR_WIDTH-1:0] idExRt;
    logic                      idExMemRead;
    logic                      branchTaken;
    logic                      memReq;
    logic                      memReady;

    logic                      pcWrite;
    logic                      ifIdWrite;
    logic                      ifIdFlush;
    logic                      idExBubble;
    logic                      pipeHold;
    logic [15:0]               stallCycles;
    logic                      memTimeout;

    // Pipeline side
    modport master (
        output ifIdRs, ifIdRt, ifIdUsesRt, idExRt, idExMemRead,
               branchTaken, memReq, memReady,
        input  pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold,
               stallCycles, memTimeout
    );

    // Hazard control unit side
    modport slave (
        input  ifIdRs, ifIdRt, ifIdUsesRt, idExRt, idExMemRead,
               branchTaken, memReq, memReady,
        output pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold,
               stallCycles, memTimeout
    );
endinterface

// File: rtl/hazard_control_unit.sv
// ----------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline sequencing controller for the 5-stage core. Sits beside the
// forwarding logic and handles what forwarding cannot:
//   - load-use hazards: one bubble into ID/EX while PC and IF/ID hold
//   - taken branches: redirect cycle plus FLUSH_CYCLES squash cycles
//   - data memory wait: whole pipeline frozen until memReady, with a
//     MEM_TIMEOUT cycle limit after which the access is abandoned
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    hazard_control_unit_if.slave (see interface for signal list)
//
// Control outputs are combinational from state and inputs so stalls take
// effect in the same cycle the hazard is seen; only the sequencing state is
// registered.
// ----------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 1,    // 1..7
    parameter int MEM_TIMEOUT    = 255   // 1..255
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_control_unit_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [2:0]  FLUSH_INIT  = 3'(FLUSH_CYCLES);
    localparam logic [7:0]  TIMEOUT_CNT = 8'(MEM_TIMEOUT);
    localparam logic [15:0] STALL_MAX   = 16'hFFFF;

    state_t      state;
    state_t      state_next;
    logic [2:0]  flush_cnt;
    logic [2:0]  flush_cnt_next;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_next;
    // Where to go once memory wait ends: 0 = RUN, 1 = FLUSH
    logic        resume_flush;
    logic        resume_flush_next;
    logic        mem_timeout;
    logic        mem_timeout_next;
    logic [15:0] stall_cycles;

    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        pipe_hold;

    logic [REG_ADDR_WIDTH-1:0] ex_rt;
    logic                      mem_stall;
    logic                      load_use;
    logic                      rs_match;
    logic                      rt_match;

    // ------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------
    assign ex_rt     = bus.idExRt;
    assign mem_stall = bus.memReq & ~bus.memReady;
    assign rs_match  = (ex_rt == bus.ifIdRs);
    assign rt_match  = bus.ifIdUsesRt & (ex_rt == bus.ifIdRt);
    // r0 is hardwired zero, so a load targeting it never creates a hazard
    assign load_use  = bus.idExMemRead & (ex_rt != '0) & (rs_match | rt_match);

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state;
        flush_cnt_next    = flush_cnt;
        wait_cnt_next     = wait_cnt;
        resume_flush_next = resume_flush;
        mem_timeout_next  = mem_timeout;

        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    pc_write          = 1'b0;
                    if_id_write       = 1'b0;
                    pipe_hold         = 1'b1;
                    resume_flush_next = 1'b0;
                    wait_cnt_next     = 8'd1;
                    state_next        = MEM_WAIT;
                end else if (bus.branchTaken) begin
                    // Redirect cycle: PC takes the target, the younger
                    // instructions in IF/ID and ID are squashed.
                    if_id_flush    = 1'b1;
                    id_ex_bubble   = 1'b1;
                    flush_cnt_next = FLUSH_INIT;
                    state_next     = FLUSH;
                end else if (load_use) begin
                    // Single bubble; the load moves to MEM next cycle and
                    // forwarding covers the dependency from there.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end

            FLUSH: begin
                if (mem_stall) begin
                    pc_write          = 1'b0;
                    if_id_write       = 1'b0;
                    pipe_hold         = 1'b1;
                    resume_flush_next = 1'b1;
                    wait_cnt_next     = 8'd1;
                    state_next        = MEM_WAIT;
                end else begin
                    // Wrong-path instructions: their hazards and branches
                    // are irrelevant, only the squash matters.
                    if_id_flush    = 1'b1;
                    flush_cnt_next = flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1) begin
                        state_next = RUN;
                    end
                end
            end

            MEM_WAIT: begin
                if (bus.memReady || (wait_cnt == TIMEOUT_CNT)) begin
                    // Release: behave like the state being resumed, but
                    // without acting on branchTaken, which is still held by
                    // the frozen EX stage and is taken up after exit.
                    if (!bus.memReady) begin
                        mem_timeout_next = 1'b1;
                    end
                    if (resume_flush) begin
                        if_id_flush = 1'b1;
                        state_next  = FLUSH;
                    end else begin
                        state_next  = RUN;
                    end
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    pipe_hold     = 1'b1;
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end

            default: begin
                state_next = RUN;
            end
        endcase

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pipe_hold    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            flush_cnt    <= 3'd0;
            wait_cnt     <= 8'd0;
            resume_flush <= 1'b0;
            mem_timeout  <= 1'b0;
        end else begin
            state        <= state_next;
            flush_cnt    <= flush_cnt_next;
            wait_cnt     <= wait_cnt_next;
            resume_flush <= resume_flush_next;
            mem_timeout  <= mem_timeout_next;
        end
    end

    // ------------------------------------------------------------------
    // Stall statistics (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 16'd0;
        end else if (!pc_write && (stall_cycles != STALL_MAX)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

    assign bus.pcWrite     = pc_write;
    assign bus.ifIdWrite   = if_id_write;
    assign bus.ifIdFlush   = if_id_flush;
    assign bus.idExBubble  = id_ex_bubble;
    assign bus.pipeHold    = pipe_hold;
    assign bus.stallCycles = stall_cycles;
    assign bus.memTimeout  = mem_timeout;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Directed bench for hazard_control_unit. Two instances share clock and
// reset:
//   dut0: FLUSH_CYCLES=1, MEM_TIMEOUT=255 (bus b0)
//   dut1: FLUSH_CYCLES=2, MEM_TIMEOUT=3   (bus b1)
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Control outputs are compared as {pcWrite,ifIdWrite,ifIdFlush,idExBubble,
// pipeHold}.
// ----------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam logic [4:0] NORMAL = 5'b11000;
    localparam logic [4:0] LU     = 5'b00010;
    localparam logic [4:0] BR     = 5'b11110;
    localparam logic [4:0] FL     = 5'b11100;
    localparam logic [4:0] HOLD   = 5'b00001;
    localparam logic [4:0] RST    = 5'b00110;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    hazard_control_unit_if #(.REG_ADDR_WIDTH(5)) b0 ();
    hazard_control_unit_if #(.REG_ADDR_WIDTH(5)) b1 ();

    hazard_control_unit #(
        .REG_ADDR_WIDTH(5), .FLUSH_CYCLES(1), .MEM_TIMEOUT(255)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );

    hazard_control_unit #(
        .REG_ADDR_WIDTH(5), .FLUSH_CYCLES(2), .MEM_TIMEOUT(3)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] ctl0();
        return {b0.pcWrite, b0.ifIdWrite, b0.ifIdFlush, b0.idExBubble, b0.pipeHold};
    endfunction

    function automatic logic [4:0] ctl1();
        return {b1.pcWrite, b1.ifIdWrite, b1.ifIdFlush, b1.idExBubble, b1.pipeHold};
    endfunction

    task automatic idle0();
        b0.ifIdRs = 5'd0; b0.ifIdRt = 5'd0; b0.ifIdUsesRt = 1'b0;
        b0.idExRt = 5'd0; b0.idExMemRead = 1'b0; b0.branchTaken = 1'b0;
        b0.memReq = 1'b0; b0.memReady = 1'b0;
    endtask

    task automatic idle1();
        b1.ifIdRs = 5'd0; b1.ifIdRt = 5'd0; b1.ifIdUsesRt = 1'b0;
        b1.idExRt = 5'd0; b1.idExMemRead = 1'b0; b1.branchTaken = 1'b0;
        b1.memReq = 1'b0; b1.memReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle0();
        idle1();
        @(negedge clk); #1;
        total++;
        if (ctl0() !== RST) begin
            bad++; $display("FAIL reset_ctl got=%b want=%b", ctl0(), RST);
        end
        @(negedge clk); reset = 1'b0; #1;
        total++;
        if (ctl0() !== NORMAL) begin
            bad++; $display("FAIL post_reset_ctl got=%b want=%b", ctl0(), NORMAL);
        end
        total++;
        if (b0.stallCycles !== 16'd0) begin
            bad++; $display("FAIL post_reset_stall got=%0d want=0", b0.stallCycles);
        end
        total++;
        if (b0.memTimeout !== 1'b0) begin
            bad++; $display("FAIL post_reset_timeout got=%b want=0", b0.memTimeout);
        end
        total++;
        if (ctl1() !== NORMAL) begin
            bad++; $display("FAIL post_reset_ctl1 got=%b want=%b", ctl1(), NORMAL);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        b0.idExMemRead = 1'b1; b0.idExRt = 5'd5; b0.ifIdRs = 5'd5; #1;
        total++;
        if (ctl0() !== LU) begin
            bad++; $display("FAIL load_use_stall got=%b want=%b", ctl0(), LU);
        end
        @(negedge clk);
        b0.idExMemRead = 1'b0; #1;
        total++;
        if (ctl0() !== NORMAL) begin
            bad++; $display("FAIL load_use_clear got=%b want=%b", ctl0(), NORMAL);
        end
        total++;
        if (b0.stallCycles !== 16'd1) begin
            bad++; $display("FAIL load_use_count got=%0d want=1", b0.stallCycles);
        end
        @(negedge clk);
        b0.idExMemRead = 1'b1; b0.idExRt = 5'd0; b0.ifIdRs = 5'd0; #1;
        total++;
        if (ctl0() !== NORMAL) begin
            bad++; $display("FAIL load_use_r0 got=%b want=%b", ctl0(), NORMAL);
        end
        @(negedge clk);
        idle0(); #1;
        total++;
        if (b0.stallCycles !== 16'd1) begin
            bad++; $display("FAIL load_use_r0_count got=%0d want=1", b0.stallCycles);
        end
    endtask

    task automatic test_rt_hazard();
        @(negedge clk);
        b0.idExMemRead = 1'b1; b0.idExRt = 5'd7; b0.ifIdRs = 5'd3;
        b0.ifIdRt = 5'd7; b0.ifIdUsesRt = 1'b0; #1;
        total++;
        if (ctl0() !== NORMAL) begin
            bad++; $display("FAIL rt_unused got=%b want=%b", ctl0(), NORMAL);
        end
        @(negedge clk);
        b0.ifIdUsesRt = 1'b1; #1;
        total++;
        if (ctl0() !== LU) begin
            bad++; $display("FAIL rt_used got=%b want=%b", ctl0(), LU);
        end
        @(negedge clk);
        idle0(); #1;
        total++;
        if (ctl0() !== NORMAL) begin
            bad++; $display("FAIL rt_clear got=%b want=%b", ctl0(), NORMAL);
        end
        total++;
        if (b0.stallCycles !== 16'd2) begin
            bad++; $display("FAIL rt_count got=%0d want=2", b0.stallCycles);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        b0.branchTaken = 1'b1; #1;
        total++;
        if (ctl0() !== BR) begin
            bad++; $display("FAIL branch_redirect got=%b want=%b", ctl0(), BR);
        end
        @(negedge clk);
        b0.branchTaken = 1'b0;
        b0.idExMemRead = 1'b1; b0.idExRt = 5'd5; b0.ifIdRs = 5'd5; #1;
        total++;
        if (ctl0() !== FL) begin
            bad++; $display("FAIL branch_flush_ignores_lu got=%b want=%b", ctl0(), FL);
        end
        @(negedge clk); #1;
        total++;
        if (ctl0() !== LU) begin
            bad++; $display("FAIL branch_back_to_run got=%b want=%b", ctl0(), LU);
        end
        @(negedge clk);
        idle0(); #1;
        total++;
        if (b0.stallCycles !== 16'd3) begin
            bad++; $display("FAIL branch_count got=%0d want=3", b0.stallCycles);
        end
    endtask

    task automatic test_flush_multi();
        @(negedge clk);
        b1.branchTaken = 1'b1; #1;
        total++;
        if (ctl1() !== BR) begin
            bad++; $display("FAIL flush2_redirect got=%b want=%b", ctl1(), BR);
        end
        @(negedge clk); #1;
        total++;
        if (ctl1() !== FL) begin
            bad++; $display("FAIL flush2_first_branch_ignored got=%b want=%b", ctl1(), FL);
        end
        @(negedge clk);
        b1.branchTaken = 1'b0; #1;
        total++;
        if (ctl1() !== FL) begin
            bad++; $display("FAIL flush2_second got=%b want=%b", ctl1(), FL);
        end
        @(negedge clk); #1;
        total++;
        if (ctl1() !== NORMAL) begin
            bad++; $display("FAIL flush2_done got=%b want=%b", ctl1(), NORMAL);
        end
    endtask

    task automatic test_mem_wait();
        @(negedge clk);
        b0.memReq = 1'b1; b0.memReady = 1'b0; b0.branchTaken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            total++;
            if (ctl0() !== HOLD) begin
                bad++; $display("FAIL mem_hold cycle=%0d got=%b want=%b", i, ctl0(), HOLD);
            end
        end
        @(negedge clk);
        b0.memReady = 1'b1; #1;
        total++;
        if (ctl0() !== NORMAL) begin
            bad++; $display("FAIL mem_release got=%b want=%b", ctl0(), NORMAL);
        end
        total++;
        if (b0.stallCycles !== 16'd7) begin
            bad++; $display("FAIL mem_count got=%0d want=7", b0.stallCycles);
        end
        @(negedge clk);
        b0.memReq = 1'b0; b0.memReady = 1'b0; #1;
        total++;
        if (ctl0() !== BR) begin
            bad++; $display("FAIL mem_branch_after got=%b want=%b", ctl0(), BR);
        end
        @(negedge clk);
        b0.branchTaken = 1'b0; #1;
        total++;
        if (ctl0() !== FL) begin
            bad++; $display("FAIL mem_branch_flush got=%b want=%b", ctl0(), FL);
        end
        @(negedge clk);
        idle0(); #1;
        total++;
        if (ctl0() !== NORMAL) begin
            bad++; $display("FAIL mem_branch_done got=%b want=%b", ctl0(), NORMAL);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        b1.memReq = 1'b1; b1.memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            total++;
            if (ctl1() !== HOLD) begin
                bad++; $display("FAIL timeout_hold cycle=%0d got=%b want=%b", i, ctl1(), HOLD);
            end
        end
        @(negedge clk); #1;
        total++;
        if (ctl1() !== NORMAL) begin
            bad++; $display("FAIL timeout_release got=%b want=%b", ctl1(), NORMAL);
        end
        total++;
        if (b1.memTimeout !== 1'b0) begin
            bad++; $display("FAIL timeout_flag_early got=%b want=0", b1.memTimeout);
        end
        @(negedge clk);
        b1.memReq = 1'b0; #1;
        total++;
        if (b1.memTimeout !== 1'b1) begin
            bad++; $display("FAIL timeout_flag got=%b want=1", b1.memTimeout);
        end
        total++;
        if (b1.stallCycles !== 16'd3) begin
            bad++; $display("FAIL timeout_count got=%0d want=3", b1.stallCycles);
        end
        @(negedge clk);
        b1.memReq = 1'b1; b1.memReady = 1'b1; #1;
        total++;
        if (ctl1() !== NORMAL) begin
            bad++; $display("FAIL timeout_ready_access got=%b want=%b", ctl1(), NORMAL);
        end
        @(negedge clk);
        idle1(); #1;
        total++;
        if (b1.memTimeout !== 1'b1) begin
            bad++; $display("FAIL timeout_sticky got=%b want=1", b1.memTimeout);
        end
    endtask

    task automatic test_mem_resume_flush();
        @(negedge clk);
        b1.branchTaken = 1'b1; #1;
        total++;
        if (ctl1() !== BR) begin
            bad++; $display("FAIL resume_redirect got=%b want=%b", ctl1(), BR);
        end
        @(negedge clk);
        b1.branchTaken = 1'b0; b1.memReq = 1'b1; b1.memReady = 1'b0; #1;
        total++;
        if (ctl1() !== HOLD) begin
            bad++; $display("FAIL resume_hold got=%b want=%b", ctl1(), HOLD);
        end
        @(negedge clk);
        b1.memReady = 1'b1; #1;
        total++;
        if (ctl1() !== FL) begin
            bad++; $display("FAIL resume_flush_release got=%b want=%b", ctl1(), FL);
        end
        @(negedge clk);
        idle1(); #1;
        total++;
        if (ctl1() !== FL) begin
            bad++; $display("FAIL resume_flush_cont got=%b want=%b", ctl1(), FL);
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (ctl1() !== NORMAL) begin
            bad++; $display("FAIL resume_flush_done got=%b want=%b", ctl1(), NORMAL);
        end
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        b0.branchTaken = 1'b1; #1;
        total++;
        if (ctl0() !== BR) begin
            bad++; $display("FAIL rstflush_redirect got=%b want=%b", ctl0(), BR);
        end
        @(negedge clk);
        b0.branchTaken = 1'b0; b0.memReq = 1'b1; b0.memReady = 1'b0; #1;
        total++;
        if (ctl0() !== HOLD) begin
            bad++; $display("FAIL rstflush_hold1 got=%b want=%b", ctl0(), HOLD);
        end
        @(negedge clk); #1;
        total++;
        if (ctl0() !== HOLD) begin
            bad++; $display("FAIL rstflush_hold2 got=%b want=%b", ctl0(), HOLD);
        end
        @(negedge clk);
        reset = 1'b1; #1;
        total++;
        if (ctl0() !== RST) begin
            bad++; $display("FAIL rstflush_reset_ctl got=%b want=%b", ctl0(), RST);
        end
        @(negedge clk);
        reset = 1'b0;
        idle0(); #1;
        total++;
        if (ctl0() !== NORMAL) begin
            bad++; $display("FAIL rstflush_after got=%b want=%b", ctl0(), NORMAL);
        end
        total++;
        if (b0.stallCycles !== 16'd0) begin
            bad++; $display("FAIL rstflush_count got=%0d want=0", b0.stallCycles);
        end
        total++;
        if (b1.memTimeout !== 1'b0) begin
            bad++; $display("FAIL rstflush_timeout_cleared got=%b want=0", b1.memTimeout);
        end
        @(negedge clk); #1;
        total++;
        if (ctl0() !== NORMAL) begin
            bad++; $display("FAIL rstflush_no_residual got=%b want=%b", ctl0(), NORMAL);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_load_use();
        test_rt_hazard();
        test_branch();
        test_flush_multi();
        test_mem_wait();
        test_timeout();
        test_mem_resume_flush();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
